// File: rtl/parking_gate_scheduler_if.sv
// Lane/gate signal bundle for parking_gate_scheduler.
// master: lane controllers and gate sensor side (drives requests and pass
//         events, observes grants and gate commands).
// slave:  the scheduler (observes requests/pass, drives grants, gate
//         commands, occupancy, full flag and timeout alarm).
interface parking_gate_scheduler_if #(
  parameter int unsigned CNT_W = 5
);
  logic             req_in;
  logic             req_out;
  logic             pass_evt;
  logic             grant_in;
  logic             grant_out;
  logic             gate_o;
  logic             gate_cls;
  logic             lot_full;
  logic [CNT_W-1:0] occupancy;
  logic             timeout_alm;

  modport master (
    output req_in, req_out, pass_evt,
    input  grant_in, grant_out, gate_o, gate_cls, lot_full, occupancy,
           timeout_alm
  );

  modport slave (
    input  req_in, req_out, pass_evt,
    output grant_in, grant_out, gate_o, gate_cls, lot_full, occupancy,
           timeout_alm
  );
endinterface

// File: rtl/parking_gate_scheduler.sv
// Arbitrates one barrier gate between an entry and an exit lane and tracks
// lot occupancy against CAPACITY.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous, active-high
//   gate_bus - slave side of parking_gate_scheduler_if:
//              req_in/req_out (lane requests), pass_evt (vehicle passed),
//              grant_in/grant_out, gate_o (open), gate_cls (close),
//              lot_full, occupancy, timeout_alm (grant expired pulse)
module parking_gate_scheduler #(
  parameter int unsigned CAPACITY  = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned CLOSE_CYC = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  parking_gate_scheduler_if.slave  gate_bus
);

  localparam int unsigned GT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CT_W = $clog2(CLOSE_CYC + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    GRANT_IN  = 4'b0010,
    GRANT_OUT = 4'b0100,
    CLOSING   = 4'b1000
  } state_t;

  // Which lane was granted most recently; drives round-robin on contest.
  typedef enum logic {
    LANE_IN  = 1'b0,
    LANE_OUT = 1'b1
  } lane_t;

  state_t           state_q, state_d;
  lane_t            last_q, last_d;
  logic [GT_W-1:0]  gtmr_q, gtmr_d;
  logic [CT_W-1:0]  ctmr_q, ctmr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             alarm_q, alarm_d;

  logic elig_in;
  logic elig_out;

  assign elig_in  = gate_bus.req_in  && (occ_q < CNT_W'(CAPACITY));
  assign elig_out = gate_bus.req_out && (occ_q != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LANE_OUT;
      gtmr_q  <= '0;
      ctmr_q  <= '0;
      occ_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gtmr_q  <= gtmr_d;
      ctmr_q  <= ctmr_d;
      occ_q   <= occ_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gtmr_d  = gtmr_q;
    ctmr_d  = ctmr_q;
    occ_d   = occ_q;
    alarm_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        gtmr_d = '0;
        ctmr_d = '0;
        if (elig_in && (!elig_out || last_q == LANE_OUT)) begin
          state_d = GRANT_IN;
          last_d  = LANE_IN;
        end else if (elig_out) begin
          state_d = GRANT_OUT;
          last_d  = LANE_OUT;
        end
      end

      GRANT_IN, GRANT_OUT: begin
        ctmr_d = '0;
        // A pass in the final timer cycle takes priority over the alarm.
        if (gate_bus.pass_evt) begin
          occ_d   = (state_q == GRANT_IN) ? occ_q + 1'b1 : occ_q - 1'b1;
          state_d = CLOSING;
        end else if (gtmr_q == GT_W'(TIMEOUT - 1)) begin
          alarm_d = 1'b1;
          state_d = CLOSING;
        end else begin
          gtmr_d = gtmr_q + 1'b1;
        end
      end

      CLOSING: begin
        if (ctmr_q == CT_W'(CLOSE_CYC - 1)) begin
          state_d = IDLE;
          ctmr_d  = '0;
        end else begin
          ctmr_d = ctmr_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gate_bus.grant_in    = (state_q == GRANT_IN);
  assign gate_bus.grant_out   = (state_q == GRANT_OUT);
  assign gate_bus.gate_o      = (state_q == GRANT_IN) || (state_q == GRANT_OUT);
  assign gate_bus.gate_cls    = (state_q == CLOSING);
  assign gate_bus.lot_full    = (occ_q == CNT_W'(CAPACITY));
  assign gate_bus.occupancy   = occ_q;
  assign gate_bus.timeout_alm = alarm_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
module tb_parking_gate_scheduler;

  localparam int unsigned CNT_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  parking_gate_scheduler_if #(.CNT_W(CNT_W)) bus ();

  parking_gate_scheduler #(
    .CAPACITY (16),
    .CNT_W    (CNT_W),
    .TIMEOUT  (200),
    .CLOSE_CYC(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .gate_bus(bus)
  );

  always #5 clock = ~clock;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic gi, input logic go,
                          input logic op, input logic cl, input int unsigned occ);
    chk({tag, ".grant_in"},  32'(bus.grant_in),  32'(gi));
    chk({tag, ".grant_out"}, 32'(bus.grant_out), 32'(go));
    chk({tag, ".gate_o"},    32'(bus.gate_o),    32'(op));
    chk({tag, ".gate_cls"},  32'(bus.gate_cls),  32'(cl));
    chk({tag, ".occupancy"}, 32'(bus.occupancy), occ);
  endtask

  // One complete entry (or exit) transaction starting and ending in IDLE.
  task automatic do_lane(input logic entry);
    if (entry) bus.req_in = 1'b1; else bus.req_out = 1'b1;
    tick(1);
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b0;
    bus.pass_evt = 1'b1;
    tick(1);
    bus.pass_evt = 1'b0;
    tick(4);
  endtask

  initial begin
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b0;
    bus.pass_evt = 1'b0;

    // Reset state
    tick(2);
    chk_outs("rst", 0, 0, 0, 0, 0);
    chk("rst.lot_full", 32'(bus.lot_full), 0);
    chk("rst.alarm", 32'(bus.timeout_alm), 0);
    reset = 1'b0;
    tick(1);

    // Single entry: grant 1 cycle after request, pass 3 cycles later
    bus.req_in = 1'b1;
    tick(1);
    bus.req_in = 1'b0;
    chk_outs("t1.grant", 1, 0, 1, 0, 0);
    tick(3);
    chk_outs("t1.held", 1, 0, 1, 0, 0);
    bus.pass_evt = 1'b1;
    tick(1);
    bus.pass_evt = 1'b0;
    chk_outs("t1.cls1", 0, 0, 0, 1, 1);
    tick(3);
    chk_outs("t1.cls4", 0, 0, 0, 1, 1);
    tick(1);
    chk_outs("t1.idle", 0, 0, 0, 0, 1);

    // Bring occupancy to 5 with last served = OUT
    for (int unsigned i = 0; i < 5; i++) do_lane(1'b1);
    do_lane(1'b0);
    chk("t2.pre_occ", 32'(bus.occupancy), 5);

    // Round robin with both lanes requesting continuously
    bus.req_in  = 1'b1;
    bus.req_out = 1'b1;
    tick(1);
    chk("rr1.grant_in", 32'(bus.grant_in), 1);
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("rr1.occ", 32'(bus.occupancy), 6);
    tick(4); tick(1);
    chk("rr2.grant_out", 32'(bus.grant_out), 1);
    chk("rr2.not_in", 32'(bus.grant_in), 0);
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("rr2.occ", 32'(bus.occupancy), 5);
    tick(4); tick(1);
    chk("rr3.grant_in", 32'(bus.grant_in), 1);
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("rr3.occ", 32'(bus.occupancy), 6);
    tick(4); tick(1);
    chk("rr4.grant_out", 32'(bus.grant_out), 1);
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("rr4.occ", 32'(bus.occupancy), 5);
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    tick(4);

    // Fill the lot, entry refused when full, exit still served
    for (int unsigned i = 0; i < 11; i++) do_lane(1'b1);
    chk("full.occ", 32'(bus.occupancy), 16);
    chk("full.flag", 32'(bus.lot_full), 1);
    bus.req_in = 1'b1;
    tick(3);
    chk_outs("full.refuse", 0, 0, 0, 0, 16);
    bus.req_out = 1'b1;
    tick(1);
    chk("full.grant_out", 32'(bus.grant_out), 1);
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("full.occ15", 32'(bus.occupancy), 15);
    chk("full.flag0", 32'(bus.lot_full), 0);
    tick(4);

    // Timeout with no pass: alarm exactly at g+200
    bus.req_in = 1'b1;
    tick(1);
    bus.req_in = 1'b0;
    chk("to.grant", 32'(bus.grant_in), 1);
    tick(199);
    chk("to.last_grant", 32'(bus.grant_in), 1);
    chk("to.no_alarm_yet", 32'(bus.timeout_alm), 0);
    tick(1);
    chk("to.alarm", 32'(bus.timeout_alm), 1);
    chk_outs("to.closing", 0, 0, 0, 1, 15);
    tick(1);
    chk("to.alarm_pulse", 32'(bus.timeout_alm), 0);
    tick(3);

    // Pass in the final grant cycle wins over the timeout
    bus.req_in = 1'b1;
    tick(1);
    bus.req_in = 1'b0;
    tick(199);
    chk("tp.last_grant", 32'(bus.grant_in), 1);
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("tp.no_alarm", 32'(bus.timeout_alm), 0);
    chk_outs("tp.closing", 0, 0, 0, 1, 16);
    tick(4);
    chk("tp.full", 32'(bus.lot_full), 1);

    // Reset during GRANT_OUT
    bus.req_out = 1'b1;
    tick(1);
    bus.req_out = 1'b0;
    chk("rg.grant_out", 32'(bus.grant_out), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_outs("rg.after", 0, 0, 0, 0, 0);
    chk("rg.lot_full", 32'(bus.lot_full), 0);

    // Reset during CLOSING
    bus.req_in = 1'b1; tick(1); bus.req_in = 1'b0;
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk_outs("rc.closing", 0, 0, 0, 1, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_outs("rc.after", 0, 0, 0, 0, 0);

    // Empty lot: exit refused, pass in IDLE ignored
    bus.req_out = 1'b1;
    tick(3);
    chk("empty.no_grant", 32'(bus.grant_out), 0);
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("empty.occ", 32'(bus.occupancy), 0);
    bus.req_out = 1'b0;

    // Contest after reset goes to entry
    bus.req_in  = 1'b1;
    bus.req_out = 1'b1;
    tick(1);
    chk("post_rst.grant_in", 32'(bus.grant_in), 1);
    chk("post_rst.grant_out", 32'(bus.grant_out), 0);
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    tick(1);
    // pass in CLOSING ignored
    bus.pass_evt = 1'b1; tick(1); bus.pass_evt = 1'b0;
    chk("cls_pass.occ", 32'(bus.occupancy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
